apb3_mailbox: RTL

//  APB3 completer sitting directly downstream of the AHB-to-APB3 bridge on its PSEL/PENABLE/PADDR bus.

---
 rtl/apb3_mailbox_pkg.sv | 24 ++
 rtl/apb3_mailbox_fifo.sv | 80 ++++++++
 rtl/apb3_mailbox.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb3_mailbox_pkg.sv
// Shared register map, bit positions and APB handshake state encoding for the mailbox.
package apb3_mailbox_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'b00;
    localparam logic [1:0] ADDR_RXDATA = 2'b01;
    localparam logic [1:0] ADDR_STATUS = 2'b10;
    localparam logic [1:0] ADDR_CTRL   = 2'b11;

    localparam int unsigned CTRL_RX_IE    = 0;
    localparam int unsigned CTRL_TX_IE    = 1;
    localparam int unsigned CTRL_TX_FLUSH = 8;
    localparam int unsigned CTRL_RX_FLUSH = 9;

    localparam int unsigned STATUS_TX_CNT_LSB = 16;
    localparam int unsigned STATUS_TX_FULL    = 30;
    localparam int unsigned STATUS_RX_EMPTY   = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } apb_state_e;

endpackage

// File: rtl/apb3_mailbox_fifo.sv
// Synchronous FIFO with flush; push when full and pop when empty are ignored.
module apb3_mailbox_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  count_nxt,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;

    // Next-state for storage, pointers and occupancy; flush overrides any push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/apb3_mailbox.sv
// APB3 completer exposing a CPU->fabric TX FIFO and a fabric->CPU RX FIFO.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access in flight; waiting for PSEL & PENABLE
// ST_WAIT | wait state (PREADY=0); side effects commit leaving this state
// ST_RESP | PREADY=1, registered PRDATA/PSLVERR presented to the bridge
module apb3_mailbox
    import apb3_mailbox_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              irq
);

    apb_state_e        state_q, state_d;
    logic [1:0]        ctrl_ie_q, ctrl_ie_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              irq_q, irq_d;

    logic              commit;
    logic              tx_push, tx_flush, rx_pop, rx_flush;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_nxt, rx_cnt, rx_cnt_nxt;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_dout;
    logic [31:0]       status_word;
    logic              unused_addr;

    assign unused_addr = ^{PADDR[31:4], PADDR[1:0]};

    apb3_mailbox_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (tx_push),
        .push_data (PWDATA[DATA_W-1:0]),
        .pop       (tx_ready),
        .flush     (tx_flush),
        .dout      (tx_data),
        .count     (tx_cnt),
        .count_nxt (tx_cnt_nxt),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    apb3_mailbox_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .flush     (rx_flush),
        .dout      (rx_dout),
        .count     (rx_cnt),
        .count_nxt (rx_cnt_nxt),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign PREADY   = (state_q == ST_RESP);
    assign PRDATA   = prdata_q;
    assign PSLVERR  = pslverr_q;
    assign irq      = irq_q;

    // Only the WAIT->RESP edge commits, and only if the bridge still holds PSEL.
    assign commit = (state_q == ST_WAIT) && PSEL;

    // Assemble the read-only STATUS word from current FIFO state.
    always_comb begin
        status_word                                  = '0;
        status_word[CNT_W-1:0]                       = rx_cnt;
        status_word[STATUS_TX_CNT_LSB +: CNT_W]      = tx_cnt;
        status_word[STATUS_TX_FULL]                  = tx_full;
        status_word[STATUS_RX_EMPTY]                 = rx_empty;
    end

    // APB handshake next-state: one wait state, abandon on PSEL drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (PSEL && PENABLE) state_d = ST_WAIT;
            ST_WAIT: state_d = PSEL ? ST_RESP : ST_IDLE;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register decode and side effects at the commit edge; irq from post-update state.
    always_comb begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        ctrl_ie_d = ctrl_ie_q;
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        tx_flush  = 1'b0;
        rx_flush  = 1'b0;
        if (commit) begin
            case (PADDR[3:2])
                ADDR_TXDATA: begin
                    if (PWRITE) begin
                        if (tx_full) pslverr_d = 1'b1;
                        else         tx_push   = 1'b1;
                    end
                end
                ADDR_RXDATA: begin
                    if (PWRITE || rx_empty) begin
                        pslverr_d = 1'b1;
                    end else begin
                        prdata_d[DATA_W-1:0] = rx_dout;
                        rx_pop               = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    if (PWRITE) pslverr_d = 1'b1;
                    else        prdata_d  = status_word;
                end
                ADDR_CTRL: begin
                    if (PWRITE) begin
                        ctrl_ie_d[0] = PWDATA[CTRL_RX_IE];
                        ctrl_ie_d[1] = PWDATA[CTRL_TX_IE];
                        tx_flush     = PWDATA[CTRL_TX_FLUSH];
                        rx_flush     = PWDATA[CTRL_RX_FLUSH];
                    end else begin
                        prdata_d[CTRL_RX_IE] = ctrl_ie_q[0];
                        prdata_d[CTRL_TX_IE] = ctrl_ie_q[1];
                    end
                end
                default: ;
            endcase
        end
        irq_d = (ctrl_ie_d[0] && (rx_cnt_nxt != '0)) ||
                (ctrl_ie_d[1] && (tx_cnt_nxt == '0));
    end

    // State, control and response registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            ctrl_ie_q <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_ie_q <= ctrl_ie_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

endmodule
